serial_adder: RTL



---
 rtl/serial_adder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder, one XOR full-adder
// slice plus a carry flop, LSB first, WIDTH cycles per operation.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   load   start request, sampled only in IDLE
//   inA    operand A, captured on the accepting edge
//   inB    operand B, captured on the accepting edge
//   sub    subtract select (only with SERIAL_ADDER_SUB_EN defined)
//   busy   high in RUN and DONE
//   done   one-cycle pulse, out/carry valid
//   out    result, held until the next DONE or reset
//   carry  carry out of the MSB, held with out
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port; the
// default build is add-only.
module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;
  logic             c;

  logic             p;
  logic             s;
  logic             c_nxt;
  logic [WIDTH-1:0] r_nxt;
  logic             last;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

  // Two XOR slices form the sum bit; p is reused as the propagate term.
  always_comb begin
    p     = sa[0] ^ sb[0];
    s     = p ^ c;
    c_nxt = (sa[0] & sb[0]) | (c & p);
    r_nxt = {s, r[WIDTH-1:1]};
    last  = (cnt == CW'(WIDTH - 1));
  end

`ifdef SERIAL_ADDER_SUB_EN
  // A - B = A + ~B + 1: invert B and seed the carry with 1.
  always_comb begin
    b_ld = sub ? ~inB : inB;
    c_ld = sub;
  end
`else
  always_comb begin
    b_ld = inB;
    c_ld = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      r     <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      carry <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            sa    <= inA;
            sb    <= b_ld;
            c     <= c_ld;
            r     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= c_nxt;
          r   <= r_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            out   <= r_nxt;
            carry <= c_nxt;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
